// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: byte FIFO feeding an 11-bit frame serialiser
// that drives ps2_clk/ps2_data like a keyboard, with host-inhibit abort and resend.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_CYCLES  = 100,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       host_inhibit,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       tx_done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(2 * HALF_PERIOD);
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CNTW-1:0] HP_C     = CNTW'(HALF_PERIOD);
  localparam logic [CNTW-1:0] HP_M1    = CNTW'(HALF_PERIOD - 1);
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(2 * HALF_PERIOD - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_t;

  // start 0, data LSB first, odd parity, stop 1; bit 0 goes on the wire first
  function automatic logic [10:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [7:0]    head;

  assign full       = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = wr_en && !full;
  assign pop        = tx_done;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic [3:0]      bit_idx;
  logic [3:0]      bit_idx_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [GW-1:0]   gap_cnt_nxt;
  logic            ps2_clk_nxt;
  logic            ps2_data_nxt;
  logic            tx_done_nxt;
  logic            load;
  logic            shift;
  logic            abortable;
  logic [10:0]     sh;

  // inhibit can abort only until the parity bit's clock has fallen
  assign abortable = (bit_idx < 4'd9) || ((bit_idx == 4'd9) && (cnt < HP_C));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    gap_cnt_nxt  = gap_cnt;
    ps2_clk_nxt  = ps2_clk;
    ps2_data_nxt = ps2_data;
    tx_done_nxt  = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    case (state)
      IDLE: begin
        ps2_clk_nxt  = 1'b1;
        ps2_data_nxt = 1'b1;
        if (!fifo_empty && !host_inhibit) begin
          state_nxt    = SEND;
          load         = 1'b1;
          cnt_nxt      = '0;
          bit_idx_nxt  = 4'd0;
          ps2_data_nxt = 1'b0;
        end
      end
      SEND: begin
        if (host_inhibit && abortable) begin
          state_nxt    = HOLD;
          ps2_clk_nxt  = 1'b1;
          ps2_data_nxt = 1'b1;
        end else if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          ps2_clk_nxt = 1'b1;
          if (bit_idx == 4'd10) begin
            state_nxt    = GAP;
            gap_cnt_nxt  = '0;
            tx_done_nxt  = 1'b1;
            ps2_data_nxt = 1'b1;
          end else begin
            bit_idx_nxt  = bit_idx + 4'd1;
            shift        = 1'b1;
            ps2_data_nxt = sh[1];
          end
        end else begin
          cnt_nxt = cnt + CNTW'(1);
          if (cnt == HP_M1) ps2_clk_nxt = 1'b0;
        end
      end
      GAP: begin
        ps2_clk_nxt  = 1'b1;
        ps2_data_nxt = 1'b1;
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt + GW'(1);
      end
      HOLD: begin
        ps2_clk_nxt  = 1'b1;
        ps2_data_nxt = 1'b1;
        if (!host_inhibit) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 4'd0;
      gap_cnt  <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      gap_cnt  <= gap_cnt_nxt;
      ps2_clk  <= ps2_clk_nxt;
      ps2_data <= ps2_data_nxt;
      tx_done  <= tx_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load) sh <= make_frame(head);
    else if (shift) sh <= sh >> 1;
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: a line monitor decodes frames at
// ps2_clk falling edges and compares them with a frame model built from bytes.
module tb_ps2_device_tx;

  localparam int HP    = 6;
  localparam int GAP   = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       host_inhibit;
  logic       full;
  logic       overflow;
  logic       busy;
  logic       tx_done;
  logic       ps2_clk;
  logic       ps2_data;

  ps2_device_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .host_inhibit(host_inhibit), .full(full), .overflow(overflow), .busy(busy),
    .tx_done(tx_done), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          falls = 0;
  int          done_cnt = 0;
  int          glitch_cnt = 0;
  int          high_run = 0;
  int          nbits = 0;
  int          done_cyc = 0;
  bit          waiting_start = 1'b1;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  logic [10:0] cur = '0;
  logic [10:0] rx_q[$];
  int          gap_meas[$];

  // line monitor: bits are captured at ps2_clk falls, a long high time drops a partial frame
  always @(negedge clk) begin
    cyc++;
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
      cur[nbits] = ps2_data;
      nbits++;
      falls++;
      if (nbits == 11) begin
        rx_q.push_back(cur);
        nbits = 0;
      end
    end
    if (prev_clk === 1'b0 && ps2_clk === 1'b0 && ps2_data !== prev_data) glitch_cnt++;
    if (ps2_clk === 1'b1) high_run++;
    else high_run = 0;
    if (high_run > 2 * HP) nbits = 0;
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      waiting_start = 1'b1;
    end else if (waiting_start && ps2_data === 1'b0) begin
      gap_meas.push_back(cyc - done_cyc);
      waiting_start = 1'b0;
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_falls(input int target, input int budget);
    for (int i = 0; i < budget && falls < target; i++) tick();
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; host_inhibit = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL reset_clk got %b exp 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL reset_data got %b exp 1", ps2_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b exp 0", tx_done); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_single();
    int startc, f0, d0, r0;
    bit ok;
    f0 = falls; d0 = done_cnt; r0 = rx_q.size();
    wr(8'h1C);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_n1 got %b exp 0", busy); end
    tick();
    checks++;
    if (busy !== 1'b1 || ps2_data !== 1'b0 || ps2_clk !== 1'b1) begin
      errors++; $display("FAIL single_start busy/clk/data got %b%b%b exp 110", busy, ps2_clk, ps2_data);
    end
    startc = cyc;
    repeat (HP - 1) tick();
    checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL single_high_phase got %b exp 1", ps2_clk); end
    tick();
    checks++; if (ps2_clk !== 1'b0) begin errors++; $display("FAIL single_first_fall got %b exp 0", ps2_clk); end
    wait_done(30 * HP, ok);
    checks++;
    if (!ok || (cyc - startc) != 22 * HP) begin
      errors++; $display("FAIL single_frame_len got %0d exp %0d", ok ? cyc - startc : -1, 22 * HP);
    end
    tick();
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", tx_done); end
    checks++;
    if (rx_q.size() <= r0) begin
      errors++; $display("FAIL single_frame got none exp %h", exp_frame(8'h1C));
    end else if (rx_q[r0] !== exp_frame(8'h1C)) begin
      errors++; $display("FAIL single_frame got %h exp %h", rx_q[r0], exp_frame(8'h1C));
    end
    checks++; if (falls - f0 != 11) begin errors++; $display("FAIL single_falls got %0d exp 11", falls - f0); end
    repeat (GAP + 60) tick();
    checks++;
    if (busy !== 1'b0 || falls != f0 + 11 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL single_fifo_empty busy %b falls %0d dones %0d exp 0 11 1", busy, falls - f0, done_cnt - d0);
    end
  endtask

  task automatic test_parity();
    int r0;
    r0 = rx_q.size();
    wr(8'hF0);
    wait_rx(r0 + 1, 30 * HP);
    checks++;
    if (rx_q.size() <= r0) begin
      errors++; $display("FAIL parity_frame got none exp %h", exp_frame(8'hF0));
    end else if (rx_q[r0] !== exp_frame(8'hF0)) begin
      errors++; $display("FAIL parity_frame got %h exp %h", rx_q[r0], exp_frame(8'hF0));
    end
    repeat (2 * HP + GAP + 5) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[4];
    int r0, g0;
    r0 = rx_q.size(); g0 = gap_meas.size();
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = b[i];
      tick();
    end
    wr_en = 1'b0;
    wait_rx(r0 + 4, 4 * (24 * HP + GAP + 10));
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q.size() <= r0 + i) begin
        errors++; $display("FAIL b2b_frame%0d got none exp %h", i, exp_frame(b[i]));
      end else if (rx_q[r0+i] !== exp_frame(b[i])) begin
        errors++; $display("FAIL b2b_frame%0d got %h exp %h", i, rx_q[r0+i], exp_frame(b[i]));
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (gap_meas.size() <= g0 + i) begin
        errors++; $display("FAIL b2b_gap%0d got none exp %0d", i, GAP + 1);
      end else if (gap_meas[g0+i] != GAP + 1) begin
        errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, gap_meas[g0+i], GAP + 1);
      end
    end
    checks++; if (glitch_cnt != 0) begin errors++; $display("FAIL data_stable_low got %0d changes exp 0", glitch_cnt); end
    repeat (2 * HP + GAP + 5) tick();
  endtask

  task automatic test_fifo_full();
    int r0;
    r0 = rx_q.size();
    host_inhibit = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      if (i == 7) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_after7 got %b exp 0", full); end
      end
      if (i == 8) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after8 got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_after8 got %b exp 0", overflow); end
      end
      if (i == 9) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_after9 got %b exp 1", overflow); end
      end
    end
    wr_en = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inhibit_idle_busy got %b exp 0", busy); end
    host_inhibit = 1'b0;
    wait_rx(r0 + 8, 8 * (24 * HP + GAP + 10));
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_q.size() <= r0 + i) begin
        errors++; $display("FAIL fifo_frame%0d got none exp %h", i, exp_frame(8'(i + 1)));
      end else if (rx_q[r0+i] !== exp_frame(8'(i + 1))) begin
        errors++; $display("FAIL fifo_frame%0d got %h exp %h", i, rx_q[r0+i], exp_frame(8'(i + 1)));
      end
    end
    repeat (24 * HP + GAP) tick();
    checks++; if (rx_q.size() != r0 + 8) begin errors++; $display("FAIL fifo_dropped got %0d frames exp 8", rx_q.size() - r0); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_inhibit_abort();
    int r0, d0, f0, rel;
    r0 = rx_q.size(); d0 = done_cnt; f0 = falls;
    wr(8'h1C);
    wait_falls(f0 + 5, 30 * HP);
    host_inhibit = 1'b1;
    tick();
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      errors++; $display("FAIL abort_lines got %b%b exp 11", ps2_clk, ps2_data);
    end
    repeat (3 * HP) tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt - d0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_hold_busy got %b exp 1", busy); end
    host_inhibit = 1'b0;
    rel = cyc;
    for (int i = 0; i < 4 * GAP && ps2_data !== 1'b0; i++) tick();
    checks++;
    if (cyc - rel != GAP + 2) begin errors++; $display("FAIL resend_latency got %0d exp %0d", cyc - rel, GAP + 2); end
    wait_rx(r0 + 1, 30 * HP);
    checks++;
    if (rx_q.size() != r0 + 1) begin
      errors++; $display("FAIL resend_count got %0d exp 1", rx_q.size() - r0);
    end else if (rx_q[r0] !== exp_frame(8'h1C)) begin
      errors++; $display("FAIL resend_frame got %h exp %h", rx_q[r0], exp_frame(8'h1C));
    end
    repeat (2 * HP + GAP + 5) tick();
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL resend_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_inhibit_late();
    logic [7:0] b;
    int r0, d0, f0;
    bit ok;
    b = 8'($urandom_range(0, 255));
    r0 = rx_q.size(); d0 = done_cnt; f0 = falls;
    wr(b);
    wait_falls(f0 + 9, 30 * HP);
    repeat (2 * HP - 1) tick();
    host_inhibit = 1'b1;
    tick();
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || falls != f0 + 9) begin
      errors++; $display("FAIL abort_before_10th got %b%b falls %0d exp 11 falls 9", ps2_clk, ps2_data, falls - f0);
    end
    repeat (3 * HP) tick();
    host_inhibit = 1'b0;
    f0 = falls;
    wait_falls(f0 + 10, 30 * HP + GAP);
    host_inhibit = 1'b1;
    wait_done(4 * HP, ok);
    checks++; if (!ok) begin errors++; $display("FAIL late_inhibit_done got 0 exp 1"); end
    checks++;
    if (rx_q.size() != r0 + 1) begin
      errors++; $display("FAIL late_inhibit_count got %0d exp 1", rx_q.size() - r0);
    end else if (rx_q[r0] !== exp_frame(b)) begin
      errors++; $display("FAIL late_inhibit_frame got %h exp %h", rx_q[r0], exp_frame(b));
    end
    host_inhibit = 1'b0;
    repeat (GAP + 5) tick();
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL late_inhibit_dones got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int r0, f0;
    f0 = falls;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    wr_en = 1'b0;
    wait_falls(f0 + 5, 30 * HP);
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_before_rst got %b exp 1", overflow); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rst_mid clk/data/busy/full/ovf got %b%b%b%b%b exp 11000",
                         ps2_clk, ps2_data, busy, full, overflow);
    end
    f0 = falls;
    repeat (300) tick();
    checks++;
    if (falls != f0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet falls %0d busy %b exp 0 0", falls - f0, busy);
    end
    b = 8'($urandom_range(0, 255));
    r0 = rx_q.size();
    wr(b);
    wait_rx(r0 + 1, 30 * HP);
    checks++;
    if (rx_q.size() <= r0) begin
      errors++; $display("FAIL rst_mid_new got none exp %h", exp_frame(b));
    end else if (rx_q[r0] !== exp_frame(b)) begin
      errors++; $display("FAIL rst_mid_new got %h exp %h", rx_q[r0], exp_frame(b));
    end
    repeat (2 * HP + GAP + 30) tick();
    checks++; if (rx_q.size() != r0 + 1) begin errors++; $display("FAIL rst_mid_flushed got %0d frames exp 1", rx_q.size() - r0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_inhibit_abort();
    test_inhibit_late();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
